// File: rtl/qam_pkg.sv
// Shared types and helpers for the M-QAM modulator: mode encoding, symbol
// size per mode, and the Gray-coded per-axis amplitude levels.
package qam_pkg;

  localparam int KMAX = 6;

  typedef enum logic [1:0] {
    MODE_QPSK  = 2'd0,
    MODE_16QAM = 2'd1,
    MODE_64QAM = 2'd2
  } qam_mode_e;

  // Reserved encoding 3 collapses onto QPSK.
  function automatic qam_mode_e to_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_16QAM;
      2'd2:    return MODE_64QAM;
      default: return MODE_QPSK;
    endcase
  endfunction

  function automatic int unsigned bits_per_sym(input qam_mode_e mode);
    case (mode)
      MODE_16QAM: return 4;
      MODE_64QAM: return 6;
      default:    return 2;
    endcase
  endfunction

  // A zero-padded narrower code converts identically through the 3-bit form.
  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic int axis_level(input logic [2:0] g, input int h);
    logic [2:0] m;
    m = g & ((3'(1) << h) - 3'(1));
    return 2 * int'(gray2bin(m)) - ((1 << h) - 1);
  endfunction

endpackage

// File: rtl/qam_bit_gearbox.sv
// Bit gearbox: packs IN_W-bit words into an LSB-first buffer and offers
// k-bit symbols for the latched mode, with zero-padded flush of residue.
module qam_bit_gearbox
  import qam_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     mode_i,
  input  logic [IN_W-1:0]                data_i,
  input  logic                           data_valid_i,
  output logic                           data_ready_o,
  input  logic                           flush_i,
  output logic [KMAX-1:0]                sym_o,
  output qam_mode_e                      sym_mode_o,
  output logic                           sym_valid_o,
  input  logic                           sym_ready_i,
  output logic [$clog2(IN_W+KMAX+1)-1:0] cnt_o,
  output logic                           flush_pend_o
);

  localparam int CAP = IN_W + KMAX;
  localparam int CW  = $clog2(CAP + 1);

  logic [CAP-1:0] buf_q, buf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  qam_mode_e      mode_q, mode_d;
  logic           flush_q, flush_d;
  logic           ready_q, ready_d;

  logic [CW-1:0]  k, take;
  logic [CAP-1:0] word_ext;
  logic           full_sym, pad_sym, ext, acc;

  always_comb begin
    k        = CW'(bits_per_sym(mode_q));
    full_sym = (cnt_q >= k);
    // Residue shorter than a symbol only leaves the buffer under a flush.
    pad_sym  = flush_q && (cnt_q != '0) && !full_sym;
    ext      = (full_sym || pad_sym) && sym_ready_i;
    acc      = data_valid_i && ready_q;
    take     = '0;
    if (ext) take = full_sym ? k : cnt_q;

    word_ext = CAP'(data_i);
    buf_d    = buf_q >> take;
    cnt_d    = cnt_q - take;
    if (acc) begin
      buf_d = buf_d | (word_ext << cnt_d);
      cnt_d = cnt_d + CW'(IN_W);
    end

    mode_d = mode_q;
    if (cnt_q == '0) mode_d = to_mode(mode_i);

    flush_d = flush_q;
    if (flush_q && ((cnt_q == '0) || (ext && pad_sym))) flush_d = 1'b0;
    if (flush_i) flush_d = 1'b1;

    ready_d = !flush_d && (cnt_d <= CW'(CAP - IN_W));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_QPSK;
      flush_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      flush_q <= flush_d;
      ready_q <= ready_d;
    end
  end

  // Bits above the count are always zero, so the pad symbol needs no extra masking.
  assign sym_o        = buf_q[KMAX-1:0] & ((KMAX'(1) << k) - KMAX'(1));
  assign sym_mode_o   = mode_q;
  assign sym_valid_o  = full_sym || pad_sym;
  assign data_ready_o = ready_q;
  assign cnt_o        = cnt_q;
  assign flush_pend_o = flush_q;

endmodule

// File: rtl/mqam_modulator.sv
// M-QAM modulator top: bit gearbox followed by a registered Gray mapper
// that turns each k-bit symbol into scaled signed I/Q samples.
module mqam_modulator
  import qam_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int DATA_W     = 16,
  parameter int SCALE_QPSK = 11585,
  parameter int SCALE_16   = 5181,
  parameter int SCALE_64   = 2528
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode_i,
  input  logic [IN_W-1:0]          data_i,
  input  logic                     data_valid_i,
  output logic                     data_ready_o,
  input  logic                     flush_i,
  output logic signed [DATA_W-1:0] data_o_i,
  output logic signed [DATA_W-1:0] data_o_q,
  output logic                     sym_valid_o,
  input  logic                     sym_ready_i,
  output logic                     busy_o
);

  localparam int CW = $clog2(IN_W + KMAX + 1);

  logic [KMAX-1:0] gb_sym;
  qam_mode_e       gb_mode;
  logic            gb_valid, gb_ready, gb_flush;
  logic [CW-1:0]   gb_cnt;

  qam_bit_gearbox #(.IN_W(IN_W)) u_gb (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .flush_i      (flush_i),
    .sym_o        (gb_sym),
    .sym_mode_o   (gb_mode),
    .sym_valid_o  (gb_valid),
    .sym_ready_i  (gb_ready),
    .cnt_o        (gb_cnt),
    .flush_pend_o (gb_flush)
  );

  logic signed [DATA_W-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic                     vld_q;
  logic [2:0]               gi, gq;
  int                       h, scale, lvl_i, lvl_q;

  assign gb_ready = !vld_q || sym_ready_i;

  always_comb begin
    gi    = {2'b00, gb_sym[0]};
    gq    = {2'b00, gb_sym[1]};
    h     = 1;
    scale = SCALE_QPSK;
    case (gb_mode)
      MODE_16QAM: begin
        gi    = {1'b0, gb_sym[1:0]};
        gq    = {1'b0, gb_sym[3:2]};
        h     = 2;
        scale = SCALE_16;
      end
      MODE_64QAM: begin
        gi    = gb_sym[2:0];
        gq    = gb_sym[5:3];
        h     = 3;
        scale = SCALE_64;
      end
      default: ;
    endcase
    lvl_i   = axis_level(gi, h);
    lvl_q   = axis_level(gq, h);
    out_i_d = DATA_W'(lvl_i * scale);
    out_q_d = DATA_W'(lvl_q * scale);
  end

  // Mapper output stage: loads only when the slot is empty or being drained.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q   <= 1'b0;
      out_i_q <= '0;
      out_q_q <= '0;
    end else if (gb_ready) begin
      vld_q <= gb_valid;
      if (gb_valid) begin
        out_i_q <= out_i_d;
        out_q_q <= out_q_d;
      end
    end
  end

  assign data_o_i    = out_i_q;
  assign data_o_q    = out_q_q;
  assign sym_valid_o = vld_q;
  assign busy_o      = (gb_cnt != '0) || vld_q || gb_flush;

endmodule

// File: tb/tb_mqam_modulator.sv
// Directed testbench for mqam_modulator: QPSK/16/64-QAM mapping, flush,
// backpressure, mode latching and mid-stream reset.
module tb_mqam_modulator;

  localparam int IN_W   = 8;
  localparam int DATA_W = 16;
  localparam int CAP    = IN_W + 6;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [1:0]               mode_i = 2'd0;
  logic [IN_W-1:0]          data_i = '0;
  logic                     data_valid_i = 1'b0;
  logic                     data_ready_o;
  logic                     flush_i = 1'b0;
  logic signed [DATA_W-1:0] data_o_i;
  logic signed [DATA_W-1:0] data_o_q;
  logic                     sym_valid_o;
  logic                     sym_ready_i = 1'b0;
  logic                     busy_o;

  mqam_modulator #(
    .IN_W(IN_W), .DATA_W(DATA_W),
    .SCALE_QPSK(11585), .SCALE_16(5181), .SCALE_64(2528)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .flush_i      (flush_i),
    .data_o_i     (data_o_i),
    .data_o_q     (data_o_q),
    .sym_valid_o  (sym_valid_o),
    .sym_ready_i  (sym_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic signed [DATA_W-1:0] qi[$];
  logic signed [DATA_W-1:0] qq[$];

  always @(posedge clk)
    if (rst && sym_valid_o && sym_ready_i) begin
      qi.push_back(data_o_i);
      qq.push_back(data_o_q);
    end

  always @(negedge clk)
    if (rst && int'(dut.u_gb.cnt_q) > CAP) begin
      errors++;
      $display("FAIL count_cap: count=%0d exceeds %0d", dut.u_gb.cnt_q, CAP);
    end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [IN_W-1:0] w);
    bit done = 0;
    data_i       = w;
    data_valid_i = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (data_ready_o) done = 1;
      tick();
    end
    data_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h not accepted, required accept", w);
    end
  endtask

  task automatic wait_syms(input int n);
    for (int t = 0; t < 200 && qi.size() < n; t++) tick();
    if (qi.size() < n) begin
      checks++;
      errors++;
      $display("FAIL sym_timeout: got %0d symbols, required %0d", qi.size(), n);
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && busy_o; t++) tick();
  endtask

  function automatic int qv(input logic b);
    return b ? 11585 : -11585;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks += 5;
    if (data_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", data_ready_o); end
    if (sym_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", sym_valid_o); end
    if (data_o_i !== 16'sd0) begin errors++; $display("FAIL rst_i: got %0d want 0", data_o_i); end
    if (data_o_q !== 16'sd0) begin errors++; $display("FAIL rst_q: got %0d want 0", data_o_q); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    rst = 1'b1;
    tick();
    checks++;
    if (data_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", data_ready_o); end
  endtask

  task automatic test_qpsk();
    int ei[4] = '{-11585, -11585, 11585, 11585};
    int eq[4] = '{11585, -11585, -11585, 11585};
    qi.delete(); qq.delete();
    mode_i = 2'd0; sym_ready_i = 1'b1;
    send_word(8'b1101_0010);
    checks++;
    if (sym_valid_o !== 1'b0) begin errors++; $display("FAIL qpsk_lat0: valid got %b want 0", sym_valid_o); end
    tick();
    checks++;
    if (sym_valid_o !== 1'b1) begin errors++; $display("FAIL qpsk_lat1: valid got %b want 1", sym_valid_o); end
    wait_syms(4);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= qi.size() || int'(qi[j]) !== ei[j] || int'(qq[j]) !== eq[j]) begin
        errors++;
        $display("FAIL qpsk_sym%0d: got (%0d,%0d) want (%0d,%0d)", j,
                 (j < qi.size()) ? int'(qi[j]) : 0, (j < qq.size()) ? int'(qq[j]) : 0, ei[j], eq[j]);
      end
    end
    wait_idle();
  endtask

  task automatic test_16qam();
    int ei[2] = '{-15543, 5181};
    int eq[2] = '{-5181, 15543};
    qi.delete(); qq.delete();
    mode_i = 2'd1; sym_ready_i = 1'b1;
    send_word(8'hB4);
    wait_syms(2);
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (j >= qi.size() || int'(qi[j]) !== ei[j] || int'(qq[j]) !== eq[j]) begin
        errors++;
        $display("FAIL qam16_sym%0d: got (%0d,%0d) want (%0d,%0d)", j,
                 (j < qi.size()) ? int'(qi[j]) : 0, (j < qq.size()) ? int'(qq[j]) : 0, ei[j], eq[j]);
      end
    end
    wait_idle();
  endtask

  task automatic test_64qam_flush();
    int ei[6] = '{7584, 7584, 7584, 7584, 7584, -7584};
    int eq[6] = '{7584, 7584, 7584, 7584, 7584, -17696};
    qi.delete(); qq.delete();
    mode_i = 2'd2; sym_ready_i = 1'b1;
    for (int w = 0; w < 4; w++) send_word(8'hFF);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_syms(6);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL qam64_busy_drop: got %b want 0", busy_o); end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (j >= qi.size() || int'(qi[j]) !== ei[j] || int'(qq[j]) !== eq[j]) begin
        errors++;
        $display("FAIL qam64_sym%0d: got (%0d,%0d) want (%0d,%0d)", j,
                 (j < qi.size()) ? int'(qi[j]) : 0, (j < qq.size()) ? int'(qq[j]) : 0, ei[j], eq[j]);
      end
    end
    tick();
    checks++;
    if (qi.size() != 6) begin errors++; $display("FAIL qam64_count: got %0d symbols want 6", qi.size()); end
    wait_idle();
  endtask

  task automatic test_flush_empty();
    qi.delete(); qq.delete();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks += 2;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL flush_empty_pend: busy got %b want 1", busy_o); end
    if (data_ready_o !== 1'b0) begin errors++; $display("FAIL flush_empty_ready0: got %b want 0", data_ready_o); end
    tick();
    checks += 3;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_empty_clear: busy got %b want 0", busy_o); end
    if (data_ready_o !== 1'b1) begin errors++; $display("FAIL flush_empty_ready1: got %b want 1", data_ready_o); end
    if (qi.size() != 0) begin errors++; $display("FAIL flush_empty_nosym: got %0d symbols want 0", qi.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3] = '{8'hD2, 8'h5A, 8'h3C};
    int k;
    qi.delete(); qq.delete();
    mode_i = 2'd0; sym_ready_i = 1'b0;
    send_word(words[0]);
    send_word(words[1]);
    data_i = words[2];
    data_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (sym_valid_o !== 1'b1 || data_ready_o !== 1'b0 ||
          int'(data_o_i) !== -11585 || int'(data_o_q) !== 11585) begin
        errors++;
        $display("FAIL b2b_hold%0d: got v=%b r=%b (%0d,%0d) want v=1 r=0 (-11585,11585)",
                 c, sym_valid_o, data_ready_o, data_o_i, data_o_q);
      end
    end
    sym_ready_i = 1'b1;
    send_word(words[2]);
    wait_syms(12);
    for (int j = 0; j < 12; j++) begin
      k = (j % 4) * 2;
      checks++;
      if (j >= qi.size() || int'(qi[j]) !== qv(words[j/4][k]) || int'(qq[j]) !== qv(words[j/4][k+1])) begin
        errors++;
        $display("FAIL b2b_sym%0d: got (%0d,%0d) want (%0d,%0d)", j,
                 (j < qi.size()) ? int'(qi[j]) : 0, (j < qq.size()) ? int'(qq[j]) : 0,
                 qv(words[j/4][k]), qv(words[j/4][k+1]));
      end
    end
    wait_idle();
  endtask

  task automatic test_mode_switch();
    int ei[8] = '{-11585, -11585, 11585, 11585, -15543, 5181, -11585, -11585};
    int eq[8] = '{11585, -11585, -11585, 11585, -5181, 15543, 11585, -11585};
    qi.delete(); qq.delete();
    mode_i = 2'd0; sym_ready_i = 1'b1;
    send_word(8'hD2);
    mode_i = 2'd1;
    wait_syms(4);
    wait_idle();
    send_word(8'hB4);
    wait_syms(6);
    wait_idle();
    mode_i = 2'd3;
    send_word(8'hD2);
    wait_syms(8);
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (j >= qi.size() || int'(qi[j]) !== ei[j] || int'(qq[j]) !== eq[j]) begin
        errors++;
        $display("FAIL mode_sym%0d: got (%0d,%0d) want (%0d,%0d)", j,
                 (j < qi.size()) ? int'(qi[j]) : 0, (j < qq.size()) ? int'(qq[j]) : 0, ei[j], eq[j]);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int ei[4] = '{-11585, -11585, 11585, 11585};
    int eq[4] = '{11585, -11585, -11585, 11585};
    qi.delete(); qq.delete();
    mode_i = 2'd2; sym_ready_i = 1'b0;
    send_word(8'hFF);
    send_word(8'hFF);
    rst = 1'b0;
    tick();
    checks += 6;
    if (sym_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", sym_valid_o); end
    if (data_o_i !== 16'sd0) begin errors++; $display("FAIL mid_rst_i: got %0d want 0", data_o_i); end
    if (data_o_q !== 16'sd0) begin errors++; $display("FAIL mid_rst_q: got %0d want 0", data_o_q); end
    if (data_ready_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", data_ready_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy_o); end
    if (int'(dut.u_gb.cnt_q) !== 0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", dut.u_gb.cnt_q); end
    rst = 1'b1;
    mode_i = 2'd0;
    sym_ready_i = 1'b1;
    tick();
    send_word(8'hD2);
    wait_syms(4);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= qi.size() || int'(qi[j]) !== ei[j] || int'(qq[j]) !== eq[j]) begin
        errors++;
        $display("FAIL post_rst_sym%0d: got (%0d,%0d) want (%0d,%0d)", j,
                 (j < qi.size()) ? int'(qi[j]) : 0, (j < qq.size()) ? int'(qq[j]) : 0, ei[j], eq[j]);
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_16qam();
    test_64qam_flush();
    test_flush_empty();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mqam_modulator.md
Name: mqam_modulator

Overview:
Parametrised successor to the fixed 2-bit QPSK modulator. It accepts a stream of IN_W-bit data words and repacks the bits into QPSK, 16-QAM or 64-QAM symbols through an internal bit gearbox. Each symbol is Gray-mapped per axis to signed I/Q samples, with valid/ready handshakes on both sides. It sits between the bit source and the channel/demodulator path and emits at most one symbol per clock.

Parameters:
IN_W, 8, input word width in bits; must be >= 6.
DATA_W, 16, signed I/Q output width.
SCALE_QPSK, 11585, unit amplitude in QPSK mode (16384/sqrt(2)).
SCALE_16, 5181, unit amplitude in 16-QAM mode (16384/sqrt(10)).
SCALE_64, 2528, unit amplitude in 64-QAM mode (16384/sqrt(42)); 7*SCALE_64 must fit DATA_W signed.

Ports:
clk  in  1  system clock, all logic on the rising edge.
rst  in  1  reset, synchronous, active-low (0 = reset).
mode_i  in  2  0=QPSK (k=2), 1=16-QAM (k=4), 2=64-QAM (k=6), 3=reserved, treated as QPSK.
data_i  in  IN_W  input bits, consumed LSB first.
data_valid_i  in  1  data_i valid.
data_ready_o  out  1  gearbox can accept a word (registered).
flush_i  in  1  one-cycle pulse: zero-pad and emit any partial symbol.
data_o_i  out  DATA_W  signed in-phase sample.
data_o_q  out  DATA_W  signed quadrature sample.
sym_valid_o  out  1  I/Q sample valid.
sym_ready_i  in  1  downstream accepts the sample.
busy_o  out  1  bit count != 0, or sym_valid_o, or flush pending.

Behaviour:
- Reset (rst=0 at an edge): bit count=0, buffer=0, latched mode=QPSK, flush pending=0, data_ready_o=0, sym_valid_o=0, data_o_i=data_o_q=0, busy_o=0. data_ready_o rises one edge after rst returns to 1. Reset mid-operation discards all buffered bits and any held symbol.
- Buffer:
  - Capacity CAP = IN_W+6; count range 0..CAP.
  - Word accepted when data_valid_i && data_ready_o.
  - data_ready_o is registered as (next count <= CAP-IN_W).
- Mode latch: mode_i is sampled into the latched mode only at an edge where count==0. Changes while count!=0 are ignored until the buffer drains.
- Symbol extraction:
  - Condition: count >= k && (!sym_valid_o || sym_ready_i).
  - Take bits b[k-1:0] from buffer LSBs, shift the buffer right by k, count -= k.
  - The same edge may also append an accepted word at bit position (count-k). Simultaneous accept+extract is mandatory.
- Latency: word accepted at edge N, first symbol valid after edge N+1. Sustained throughput is one symbol per cycle.
- Output hold: while sym_valid_o && !sym_ready_i, data_o_i, data_o_q and sym_valid_o are stable.
- Mapping, with h = k/2:
  - I uses b[h-1:0]; Q uses b[k-1:h].
  - Per axis: bin = gray2bin(g), level = 2*bin - (2^h - 1), out = level * SCALE_mode, sign-extended to DATA_W.
  - QPSK: 0→-1, 1→+1.
  - 16-QAM: 00→-3, 01→-1, 11→+1, 10→+3.
  - 64-QAM: 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- Flush:
  - flush_i sets flush pending.
  - When count < k, count > 0 and the output slot is free, emit one symbol from the remaining bits with zeros above them. Set count=0 and clear pending.
  - If count==0, pending clears immediately with no symbol.
  - While pending, data_ready_o=0.
  - flush_i with count >= k: normal extraction continues, then the padded residue is emitted.
- No overflow or underflow is possible by construction; the bench asserts that count never exceeds CAP.

Decomposition:
- Package qam_pkg:
  - mode enum (MODE_QPSK, MODE_16QAM, MODE_64QAM).
  - KMAX=6.
  - bits_per_sym(mode) function.
  - gray2bin function.
  - axis_level(g, h) function.
- Sub-module qam_bit_gearbox:
  - Contains the buffer, count, mode latch, flush logic and handshakes.
  - Outputs a k-bit symbol with valid/ready.
  - The top level adds the registered mapper stage.

Test Plan:
- QPSK, word 8'b1101_0010 → four symbols, I = -11585, -11585, +11585, +11585; Q = +11585, -11585, -11585, +11585.
- 16-QAM, word 8'hB4 → (I,Q) = (-15543, -5181), then (+5181, +15543).
- 64-QAM, four words 8'hFF then flush_i → five symbols (+7584, +7584), then padded symbol (-7584, -17696); busy_o drops after the last handshake.
- QPSK, back-to-back words with sym_ready_i=0 for 10 cycles → data_ready_o falls once count > CAP-IN_W, output held stable, no bits lost; the release stream matches a reference model.
- mode_i switched 0→1 while count!=0 → remaining symbols stay QPSK; 16-QAM applies only after drain. mode_i=3 → QPSK values.
- rst=0 asserted mid 64-QAM stream → next edge: all outputs 0, count 0; a new QPSK word after release maps correctly.
